sram_bridge16: RTL and testbench
================================

# sram_bridge16

Parametrised bridge from the 32-bit SoC peripheral bus to an external 16-bit asynchronous SRAM, e.g. the board SRAM with pins ADR/DAT/RAMCS/RAMWE/RAMOE/RAMUB/RAMLB. It splits each 32-bit command into up to two 16-bit SRAM accesses. Timing is programmable in wait states. Byte-masked writes skip halfwords whose mask is all zero. It sits inside the SoC between the bus decoder and the top-level SB_IO tristate pins.

## Interface
- SRAM_AW, 18, SRAM halfword address width; the bus byte address is SRAM_AW+1 bits.
- WAIT_CYCLES, 2, extra strobe cycles per access (0..15); strobe length is WAIT_CYCLES+1 cycles.

- io_mainClk  in  1  sole clock; all logic is on the rising edge.
- io_asyncResetn  in  1  asynchronous, active-low reset.
- io_bus_cmd_valid  in  1  command present.
- io_bus_cmd_ready  out  1  command accepted when valid&ready.
- io_bus_cmd_write  in  1  1 = write, 0 = read.
- io_bus_cmd_address  in  SRAM_AW+1  byte address; bits [1:0] ignored.
- io_bus_cmd_data  in  32  write data.
- io_bus_cmd_mask  in  4  byte enables; bit i covers data[8i+7:8i].
- io_bus_rsp_valid  out  1  one-cycle pulse with read data; never pulsed for writes.
- io_bus_rsp_data  out  32  read data, valid with rsp_valid.
- io_sram_addr  out  SRAM_AW  halfword address.
- io_sram_dat_read  in  16  data from pins.
- io_sram_dat_write  out  16  data to pins.
- io_sram_dat_writeEnable  out  1  pin output enable.
- io_sram_cs, io_sram_we, io_sram_oe, io_sram_lb, io_sram_ub  out  1 each  active-low strobes.

## Operation
- States: IDLE, RD_LO, RD_HI, RSP, WR_SETUP, WR_STROBE, WR_HOLD.
- io_bus_cmd_ready = (state==IDLE); registered state only, no combinational path from cmd_valid.
- SRAM address is {cmd_address[SRAM_AW:2], half}. Half 0 carries data[15:0]; half 1 carries data[31:16]. Address, data and mask are latched on accept.
- Read: IDLE → RD_LO → RD_HI → RSP → IDLE.
  - Each RD state lasts WAIT_CYCLES+1 cycles with cs=0, oe=0, lb=ub=0.
  - The pin data is sampled on the last cycle of each RD state.
  - RSP drives rsp_valid=1 for one cycle.
- Write: halves whose mask pair is 00 are skipped. Half 0 is processed first if enabled.
- Per enabled half:
  - WR_SETUP, 1 cycle: cs=0, we=1, writeEnable=1, data driven.
  - WR_STROBE, WAIT_CYCLES+1 cycles: we=0; lb=~mask[2h], ub=~mask[2h+1].
  - WR_HOLD, 1 cycle: we=1, data still driven.
- After the last enabled half: IDLE.
- Mask 0000: accept, no SRAM activity, IDLE on the next cycle.
- oe=1 during all write states. writeEnable=0 in every non-write state, so there is always ≥1 IDLE cycle of bus turnaround between a write and a read.
- Reset, including mid-operation: state=IDLE immediately (asynchronous).
  - Strobes cs/we/oe/lb/ub=1, writeEnable=0.
  - addr=0, dat_write=0, rsp_valid=0, rsp_data=0, cmd_ready=1.
  - The pending command is dropped and no response is produced.

## Timing
- The accept edge is cycle 0.
- Read with W=WAIT_CYCLES:
  - RD_LO occupies cycles 1..W+1; RD_HI occupies W+2..2W+2.
  - rsp_valid is high in cycle 2W+3.
  - cmd_ready returns in cycle 2W+4.
- Write:
  - A full-mask write occupies 2(W+3) cycles, then IDLE.
  - A single-half write occupies W+3 cycles.
  - Minimum write-to-write command spacing is W+4 cycles for a single half and 2W+7 for both halves.
- rsp_data holds its value until the next read response.
- A counter of ≥4 bits handles the strobe length. It reloads with WAIT_CYCLES on entry to each strobe state.

## Test plan
- Read test, W=2: preload SRAM model 0x0004=0xBEEF and 0x0005=0xDEAD, read byte address 0x8 → rsp_valid in cycle 7, rsp_data=0xDEADBEEF, oe low for cycles 1..6.
- Full write test, W=2: write 0x12345678 with mask 1111 to 0x10 → model 0x8=0x5678 and 0x9=0x1234; we low for 3 cycles per half; writeEnable high cycles 1..10; no rsp_valid.
- Partial write test: write mask 0100 to 0x10 → only half 1 is accessed, with ub=1 and lb=0; model 0x9 low byte changes; ready returns in cycle 6.
- Mask 0000: no cs assertion; cmd_ready back high in cycle 2.
- Write followed by read: writeEnable falls at least 1 cycle before oe falls; the read returns the freshly written data.
- Reset mid-write, W=0: assert io_asyncResetn=0 during WR_STROBE → we/cs=1 and writeEnable=0 immediately. After release, a read completes in cycle 3.

Source files
------------

// File: rtl/sram_bridge16.sv
// sram_bridge16: 32-bit peripheral bus to 16-bit async SRAM bridge with programmable wait states
// Ports: io_mainClk/io_asyncResetn clock and async active-low reset;
//   io_bus_cmd_* command in (valid/ready/write/address/data/mask), io_bus_rsp_* one-cycle read response;
//   io_sram_* halfword address, data in/out with output enable, active-low cs/we/oe/lb/ub strobes.
module sram_bridge16 #(
  parameter int SRAM_AW     = 18,
  parameter int WAIT_CYCLES = 2
) (
  input  logic               io_mainClk,
  input  logic               io_asyncResetn,
  input  logic               io_bus_cmd_valid,
  output logic               io_bus_cmd_ready,
  input  logic               io_bus_cmd_write,
  input  logic [SRAM_AW:0]   io_bus_cmd_address,
  input  logic [31:0]        io_bus_cmd_data,
  input  logic [3:0]         io_bus_cmd_mask,
  output logic               io_bus_rsp_valid,
  output logic [31:0]        io_bus_rsp_data,
  output logic [SRAM_AW-1:0] io_sram_addr,
  input  logic [15:0]        io_sram_dat_read,
  output logic [15:0]        io_sram_dat_write,
  output logic               io_sram_dat_writeEnable,
  output logic               io_sram_cs,
  output logic               io_sram_we,
  output logic               io_sram_oe,
  output logic               io_sram_lb,
  output logic               io_sram_ub
);
  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, RSP, WR_SETUP, WR_STROBE, WR_HOLD} state_t;
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic half_q, half_d;
  logic [SRAM_AW-2:0] addr_q;
  logic [31:0] data_q, rsp_q;
  logic [3:0] mask_q;
  logic [15:0] lo_q;
  logic [1:0] hmask;
  logic cz, rd, wa, stb;
  logic unused_addr;
  assign unused_addr = ^io_bus_cmd_address[1:0];
  assign cz = cnt_q == 4'd0;
  assign hmask = half_q ? mask_q[3:2] : mask_q[1:0];
  // A write with an all-zero mask parks one cycle in WR_HOLD with hmask=00,
  // so all write strobes below are qualified by the current half being enabled.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    half_d = half_q;
    case (state_q)
      IDLE: if (io_bus_cmd_valid) begin
        half_d = io_bus_cmd_write && io_bus_cmd_mask[1:0] == 2'b00;
        cnt_d = WC;
        state_d = !io_bus_cmd_write ? RD_LO : |io_bus_cmd_mask ? WR_SETUP : WR_HOLD;
      end
      RD_LO: begin
        cnt_d = cz ? WC : cnt_q - 4'd1;
        half_d = cz ? 1'b1 : half_q;
        state_d = cz ? RD_HI : RD_LO;
      end
      RD_HI: begin
        cnt_d = cnt_q - 4'd1;
        state_d = cz ? RSP : RD_HI;
      end
      RSP: state_d = IDLE;
      WR_SETUP: begin
        cnt_d = WC;
        state_d = WR_STROBE;
      end
      WR_STROBE: begin
        cnt_d = cnt_q - 4'd1;
        state_d = cz ? WR_HOLD : WR_STROBE;
      end
      WR_HOLD: begin
        half_d = 1'b1;
        state_d = !half_q && |mask_q[3:2] ? WR_SETUP : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      state_q <= IDLE;
      cnt_q <= 4'd0;
      half_q <= 1'b0;
      addr_q <= '0;
      data_q <= 32'd0;
      mask_q <= 4'd0;
      lo_q <= 16'd0;
      rsp_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      half_q <= half_d;
      if (state_q == IDLE && io_bus_cmd_valid) begin
        addr_q <= io_bus_cmd_address[SRAM_AW:2];
        data_q <= io_bus_cmd_data;
        mask_q <= io_bus_cmd_mask;
      end
      if (state_q == RD_LO && cz) lo_q <= io_sram_dat_read;
      if (state_q == RD_HI && cz) rsp_q <= {io_sram_dat_read, lo_q};
    end
  end
  assign rd = state_q == RD_LO || state_q == RD_HI;
  assign wa = (state_q == WR_SETUP || state_q == WR_STROBE || state_q == WR_HOLD) && |hmask;
  assign stb = state_q == WR_STROBE && |hmask;
  assign io_bus_cmd_ready = state_q == IDLE;
  assign io_bus_rsp_valid = state_q == RSP;
  assign io_bus_rsp_data = rsp_q;
  assign io_sram_addr = {addr_q, half_q};
  assign io_sram_dat_write = half_q ? data_q[31:16] : data_q[15:0];
  assign io_sram_dat_writeEnable = wa;
  assign io_sram_cs = ~(rd | wa);
  assign io_sram_oe = ~rd;
  assign io_sram_we = ~stb;
  assign io_sram_lb = ~(rd | (stb & hmask[0]));
  assign io_sram_ub = ~(rd | (stb & hmask[1]));
endmodule

// File: tb/tb_sram_bridge16.sv
// tb_sram_bridge16: randomized scoreboard bench for sram_bridge16 with an SRAM pin model
module tb_sram_bridge16;
  localparam int W = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic valid = 1'b0, ready, write = 1'b0;
  logic [18:0] address = '0;
  logic [31:0] data = '0, rsp_data;
  logic [3:0] mask = '0;
  logic rsp_valid;
  logic [17:0] sram_addr;
  logic [15:0] dat_read, dat_write;
  logic dat_en, cs, we, oe, lb, ub;
  logic [15:0] sram [0:255];
  logic [31:0] ref_mem [0:127];
  typedef struct {logic [31:0] d; int c;} exp_t;
  exp_t q[$];
  int vectors = 0, miscompares = 0, cyc = 0, last_en_cyc = -100;
  logic prev_oe = 1'b1;
  logic [31:0] last_rsp = 32'd0;

  sram_bridge16 #(.SRAM_AW(18), .WAIT_CYCLES(W)) dut (
    .io_mainClk(clk), .io_asyncResetn(rst_n),
    .io_bus_cmd_valid(valid), .io_bus_cmd_ready(ready), .io_bus_cmd_write(write),
    .io_bus_cmd_address(address), .io_bus_cmd_data(data), .io_bus_cmd_mask(mask),
    .io_bus_rsp_valid(rsp_valid), .io_bus_rsp_data(rsp_data),
    .io_sram_addr(sram_addr), .io_sram_dat_read(dat_read), .io_sram_dat_write(dat_write),
    .io_sram_dat_writeEnable(dat_en), .io_sram_cs(cs), .io_sram_we(we), .io_sram_oe(oe),
    .io_sram_lb(lb), .io_sram_ub(ub));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // external SRAM: combinational read, byte-lane writes while we is low
  assign dat_read = (!cs && !oe) ? sram[sram_addr[7:0]] : 16'h0000;
  always @(posedge clk) if (rst_n && !cs && !we && dat_en) begin
    if (!lb) sram[sram_addr[7:0]][7:0] <= dat_write[7:0];
    if (!ub) sram[sram_addr[7:0]][15:8] <= dat_write[15:8];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // monitor: response scoreboard and write-to-read turnaround
  always @(negedge clk) if (rst_n) begin
    if (rsp_valid) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rsp_unexpected: got data 0x%0h with no read outstanding", rsp_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rsp_data", rsp_data, e.d);
        chk("rsp_cycle", cyc, e.c);
      end
    end
    if (prev_oe && !oe) chk("turnaround", 32'(cyc - last_en_cyc >= 2), 32'd1);
    if (dat_en) last_en_cyc = cyc;
    prev_oe = oe;
  end

  // called at a negedge; issues one command and checks its pin-level footprint
  task automatic cmd(input logic wr, input logic [18:0] ad, input logic [31:0] d, input logic [3:0] m);
    int a, k, n, nl, nu, n_we, n_oe, n_cs, n_en, n_lb, n_ub;
    k = 0;
    while (!ready && k < 200) begin @(negedge clk); k++; end
    chk("ready_wait", 32'(ready), 32'd1);
    valid = 1'b1; write = wr; address = ad; data = d; mask = m;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    a = cyc;
    nl = int'(m[0]) + int'(m[2]);
    nu = int'(m[1]) + int'(m[3]);
    n = int'(|m[1:0]) + int'(|m[3:2]);
    if (!wr) begin
      q.push_back('{ref_mem[ad[8:2]], a + 2 * W + 2});
      last_rsp = ref_mem[ad[8:2]];
    end else for (int i = 0; i < 4; i++) if (m[i]) ref_mem[ad[8:2]][8*i+:8] = d[8*i+:8];
    n_we = 0; n_oe = 0; n_cs = 0; n_en = 0; n_lb = 0; n_ub = 0;
    k = 1;
    while (!ready && k < 100) begin
      n_we += int'(!we); n_oe += int'(!oe); n_cs += int'(!cs); n_en += int'(dat_en);
      n_lb += int'(!we && !lb); n_ub += int'(!we && !ub);
      @(negedge clk);
      k++;
    end
    chk("ready_cycle", k, !wr ? 2 * W + 4 : n == 0 ? 2 : n * (W + 3) + 1);
    chk("we_low", n_we, wr ? n * (W + 1) : 0);
    chk("oe_low", n_oe, wr ? 0 : 2 * W + 2);
    chk("cs_low", n_cs, wr ? n * (W + 3) : 2 * W + 2);
    chk("wen_high", n_en, wr ? n * (W + 3) : 0);
    chk("lb_strobe", n_lb, wr ? nl * (W + 1) : 0);
    chk("ub_strobe", n_ub, wr ? nu * (W + 1) : 0);
    chk("rsp_hold", rsp_data, last_rsp);
  endtask

  initial begin
    int k;
    for (int i = 0; i < 256; i++) sram[i] = 16'h0;
    for (int i = 0; i < 128; i++) ref_mem[i] = 32'h0;
    sram[4] = 16'hBEEF; sram[5] = 16'hDEAD; ref_mem[2] = 32'hDEADBEEF;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_strobes", {cs, we, oe, lb, ub, dat_en}, 6'b111110);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_rsp", {rsp_data[30:0], rsp_valid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    cmd(1'b0, 19'h8, 32'h0, 4'h0);
    cmd(1'b1, 19'h10, 32'h12345678, 4'hF);
    chk("sram_half0", 32'(sram[8]), 32'h5678);
    chk("sram_half1", 32'(sram[9]), 32'h1234);
    cmd(1'b1, 19'h10, 32'h00AB0000, 4'b0100);
    chk("sram_partial", 32'(sram[9]), 32'h12AB);
    cmd(1'b1, 19'h14, 32'hFFFFFFFF, 4'b0000);
    cmd(1'b0, 19'h10, 32'h0, 4'h0);
    cmd(1'b0, 19'h14, 32'h0, 4'h0);
    for (int i = 0; i < 300; i++)
      cmd(1'($urandom_range(0, 1)), 19'($urandom_range(0, 'h1DF)), $urandom, 4'($urandom));
    // reset in the middle of a write strobe
    valid = 1'b1; write = 1'b1; address = 19'h1F0; data = 32'hA5A5A5A5; mask = 4'hF;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    k = 0;
    while (we && k < 50) begin @(negedge clk); k++; end
    chk("strobe_seen", 32'(we), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_strobes", {cs, we, oe, lb, ub, dat_en}, 6'b111110);
    chk("arst_ready", 32'(ready), 32'd1);
    chk("arst_out", {14'(sram_addr), dat_write, 1'b0, rsp_valid}, 32'd0);
    chk("arst_rsp", rsp_data, 32'd0);
    last_rsp = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cmd(1'b0, 19'h10, 32'h0, 4'h0);
    for (int i = 0; i < 40; i++)
      cmd(1'($urandom_range(0, 1)), 19'($urandom_range(0, 'h1DF)), $urandom, 4'($urandom));
    repeat (5) @(negedge clk);
    chk("rsp_pending", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
